// File: rtl/mem_pkg.sv
// Shared types and helpers for the IF/MEM byte-port arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide synchronous-read RAM between IF and MEM,
// serialising 1/2/4-byte accesses and assembling little-endian read data.
//
// state | meaning
// IDLE  | arbitrate, MEM over IF; latch owner/address/data/size
// GRANT | no RAM activity, byte counter cleared
// XFER  | one byte issued per cycle (read or write)
// DONE  | one-cycle done pulse to the owner, last read byte bypassed
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  input  logic              b_flag_i,
  output logic              if_busy,
  output logic              mem_busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [2:0]          n_q, n_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                cap_vld_q, cap_vld_d;
  logic [1:0]          cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0]   asm_data;
  logic                flush_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      n_q       <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  // Read data is the captured bytes plus the byte currently on ram_din,
  // so the final byte is usable in the DONE cycle without an extra stage.
  always_comb begin
    asm_data = data_q;
    if (cap_vld_q) asm_data[{cap_idx_q, 3'b000} +: 8] = ram_din;
  end

  assign flush_if = b_flag_i && (owner_q == OWN_IF);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    cap_vld_d = cap_vld_q;
    cap_idx_d = cap_idx_q;
    if (rdy) begin
      if (cap_vld_q) begin
        data_d    = asm_data;
        cap_vld_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (mem_req) begin
            owner_d = OWN_MEM;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            we_d    = mem_we;
            n_d     = size_to_bytes(mem_size);
            data_d  = '0;
            state_d = ST_GRANT;
          end else if (if_req && !b_flag_i) begin
            owner_d = OWN_IF;
            addr_d  = if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
            n_d     = 3'd4;
            data_d  = '0;
            state_d = ST_GRANT;
          end
        end
        ST_GRANT: begin
          cnt_d   = '0;
          state_d = flush_if ? ST_IDLE : ST_XFER;
        end
        ST_XFER: begin
          if (flush_if) begin
            cap_vld_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            if (!we_q) begin
              cap_vld_d = 1'b1;
              cap_idx_d = cnt_q[1:0];
            end
            if (cnt_q == n_q - 3'd1) state_d = ST_DONE;
            else                     cnt_d   = cnt_q + 3'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // While stalled with a capture pending, hold the pending byte's address so
  // ram_din carries that byte again when rdy returns.
  always_comb begin
    ram_a = '0;
    if (!rdy && cap_vld_q)       ram_a = addr_q + ADDR_W'(cap_idx_q);
    else if (state_q == ST_XFER) ram_a = addr_q + ADDR_W'(cnt_q);
  end

  assign ram_wr    = rdy && (state_q == ST_XFER) && we_q;
  assign ram_dout  = ((state_q == ST_XFER) && we_q) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

  assign if_done   = rdy && (state_q == ST_DONE) && (owner_q == OWN_IF) && !b_flag_i;
  assign mem_done  = rdy && (state_q == ST_DONE) && (owner_q == OWN_MEM);
  assign if_data   = asm_data;
  assign mem_rdata = asm_data;
  assign if_busy   = if_req && !if_done;
  assign mem_busy  = mem_req && !mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural byte RAM.
module tb_mem_arbiter;

  logic        clk, rst, rdy;
  logic        if_req;
  logic [31:0] if_addr, if_data;
  logic        if_done;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic        b_flag_i;
  logic        if_busy, mem_busy;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_wr;

  logic [7:0]  wr_m [0:65535];
  logic [7:0]  st_bytes [4];
  int          total, passes, fails;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .b_flag_i(b_flag_i), .if_busy(if_busy), .mem_busy(mem_busy),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h100:  return 8'h13;
      32'h101:  return 8'h05;
      32'h102:  return 8'h00;
      32'h103:  return 8'h00;
      32'h200:  return 8'hAA;
      32'h201:  return 8'hBB;
      32'h202:  return 8'hCC;
      32'h203:  return 8'hDD;
      32'h2000: return 8'h11;
      32'h2001: return 8'h22;
      32'h2002: return 8'h33;
      32'h2003: return 8'h80;
      default:  return 8'hEE;
    endcase
  endfunction

  always @(posedge clk) begin
    ram_din <= rom_byte(ram_a);
    if (ram_wr) wr_m[ram_a[15:0]] <= ram_dout;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ram_wr"},    32'(ram_wr),   32'h0);
    chk({tag, "_ram_a"},     ram_a,         32'h0);
    chk({tag, "_ram_dout"},  32'(ram_dout), 32'h0);
    chk({tag, "_if_done"},   32'(if_done),  32'h0);
    chk({tag, "_mem_done"},  32'(mem_done), 32'h0);
    chk({tag, "_if_data"},   if_data,       32'h0);
    chk({tag, "_mem_rdata"}, mem_rdata,     32'h0);
  endtask

  initial begin
    total = 0; passes = 0; fails = 0;
    st_bytes[0] = 8'hEF; st_bytes[1] = 8'hBE; st_bytes[2] = 8'hAD; st_bytes[3] = 8'hDE;
    rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = 2'b00; mem_addr = '0; mem_wdata = '0; b_flag_i = 1'b0;
    step(); step();
    chk_zero("reset");
    rst = 1'b1;
    step();

    // IF word fetch at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("t1_if_busy_c0", 32'(if_busy), 32'h1);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) chk("t1_grant_ram_a", ram_a, 32'h0);
      if (c >= 2 && c <= 5) chk("t1_ram_a", ram_a, 32'h100 + 32'(c - 2));
      if (c == 6) begin
        chk("t1_if_done", 32'(if_done), 32'h1);
        chk("t1_if_data", if_data, 32'h0000_0513);
        chk("t1_if_busy", 32'(if_busy), 32'h0);
      end else chk("t1_if_done_early", 32'(if_done), 32'h0);
    end
    if_req = 1'b0;
    step();
    chk("t1_if_done_after", 32'(if_done), 32'h0);

    // MEM word store
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h1000; mem_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c >= 2 && c <= 5) begin
        chk("t2_ram_wr", 32'(ram_wr), 32'h1);
        chk("t2_ram_a", ram_a, 32'h1000 + 32'(c - 2));
        chk("t2_ram_dout", 32'(ram_dout), 32'(st_bytes[c - 2]));
      end else chk("t2_ram_wr_off", 32'(ram_wr), 32'h0);
      chk("t2_mem_done", 32'(mem_done), (c == 6) ? 32'h1 : 32'h0);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    for (int k = 0; k < 4; k++) chk("t2_ram_content", 32'(wr_m[16'h1000 + 16'(k)]), 32'(st_bytes[k]));

    // simultaneous IF and MEM byte load: MEM first
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h2003;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 2) chk("t3_mem_ram_a", ram_a, 32'h2003);
      if (c == 3) begin
        chk("t3_mem_done", 32'(mem_done), 32'h1);
        chk("t3_mem_rdata", mem_rdata, 32'h0000_0080);
        chk("t3_mem_busy", 32'(mem_busy), 32'h0);
        chk("t3_if_busy", 32'(if_busy), 32'h1);
        mem_req = 1'b0;
      end else chk("t3_mem_done_off", 32'(mem_done), 32'h0);
      if (c == 4) chk("t3_idle_ram_a", ram_a, 32'h0);
      if (c >= 6 && c <= 9) chk("t3_if_ram_a", ram_a, 32'h100 + 32'(c - 6));
      if (c == 10) begin
        chk("t3_if_done", 32'(if_done), 32'h1);
        chk("t3_if_data", if_data, 32'h0000_0513);
      end else chk("t3_if_done_off", 32'(if_done), 32'h0);
    end
    if_req = 1'b0;
    step();

    // branch flush in cycle 3 of an IF fetch
    if_req = 1'b1; if_addr = 32'h200;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 4) begin
        b_flag_i = 1'b0;
        if_addr  = 32'h100;
        chk("t4_idle_ram_a", ram_a, 32'h0);
      end
      if (c == 6) chk("t4_new_ram_a", ram_a, 32'h100);
      if (c == 10) begin
        chk("t4_if_done", 32'(if_done), 32'h1);
        chk("t4_if_data", if_data, 32'h0000_0513);
      end else chk("t4_if_done_off", 32'(if_done), 32'h0);
      if (c == 3) b_flag_i = 1'b1;
    end
    if_req = 1'b0;
    step();

    // rdy low for cycles 3..5 of an IF fetch
    if_req = 1'b1; if_addr = 32'h200;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 3) rdy = 1'b0;
      if (c == 6) rdy = 1'b1;
      #1;
      chk("t5_ram_wr", 32'(ram_wr), 32'h0);
      if (c == 9) begin
        chk("t5_if_done", 32'(if_done), 32'h1);
        chk("t5_if_data", if_data, 32'hDDCC_BBAA);
      end else chk("t5_if_done_off", 32'(if_done), 32'h0);
    end
    if_req = 1'b0;
    step();

    // reset mid halfword store at 0xFFFFFFFF, then the full run wraps to 0
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b01; mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'h0000_A55A;
    step(); step();
    chk("t6_pre_ram_wr", 32'(ram_wr), 32'h1);
    chk("t6_pre_ram_a", ram_a, 32'hFFFF_FFFF);
    rst = 1'b0;
    #1 chk_zero("t6_rst");
    step();
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 2) begin
        chk("t6_a0", ram_a, 32'hFFFF_FFFF);
        chk("t6_d0", 32'(ram_dout), 32'h5A);
        chk("t6_wr0", 32'(ram_wr), 32'h1);
      end
      if (c == 3) begin
        chk("t6_a1", ram_a, 32'h0);
        chk("t6_d1", 32'(ram_dout), 32'hA5);
        chk("t6_wr1", 32'(ram_wr), 32'h1);
      end
      chk("t6_mem_done", 32'(mem_done), (c == 4) ? 32'h1 : 32'h0);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    chk("t6_mem_ffff", 32'(wr_m[16'hFFFF]), 32'h5A);
    chk("t6_mem_0000", 32'(wr_m[16'h0000]), 32'hA5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
